// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between I-cache fills,
// D-cache fills and D-cache write-through stores.
// Ports:
//   clk, rst                       clock, async active-high reset
//   i_miss/i_miss_addr             I-cache block fill request (held until i_fill_done)
//   d_miss/d_miss_addr             D-cache block fill request (held until d_fill_done)
//   d_write/_addr/_data            write-through store (held until d_write_ack)
//   mem_en/mem_wr/mem_addr/mem_wdata  memory command
//   mem_rdata/mem_rvalid           memory read return (fixed latency)
//   fill_data/fill_word            returned word and its index within the block
//   i_fill_we/d_fill_we            cache data-array write strobes
//   i_fill_done/d_fill_done        block complete pulses
//   d_write_ack                    store issued pulse
//   busy                           arbiter is not idle
module mem_arbiter #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_miss,
   input  logic [ADDR_W-1:0]              i_miss_addr,
   input  logic                           d_miss,
   input  logic [ADDR_W-1:0]              d_miss_addr,
   input  logic                           d_write,
   input  logic [ADDR_W-1:0]              d_write_addr,
   input  logic [DATA_W-1:0]              d_write_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_rvalid,
   output logic [DATA_W-1:0]              fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_fill_done,
   output logic                           d_fill_done,
   output logic                           d_write_ack,
   output logic                           busy
);

   localparam int unsigned IDX_W  = $clog2(BLOCK_WORDS);
   localparam int unsigned CNT_W  = IDX_W + 1;
   // byte offset within a block: word index plus the byte-in-word bit
   localparam int unsigned OFF_W  = IDX_W + 1;
   localparam int unsigned BASE_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITE, I_FILL, D_FILL} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
   logic [BASE_W-1:0]  base_q, base_d;

   logic fill_state;
   logic is_write;
   logic issuing;
   logic rx_accept;
   logic rx_last;

   // block-offset bits of the request addresses are discarded by design
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

   // status decode shared by next-state and output logic
   always_comb begin
      fill_state = (state_q == I_FILL) || (state_q == D_FILL);
      is_write   = (state_q == WRITE);
      issuing    = fill_state && (issue_cnt_q < CNT_W'(BLOCK_WORDS));
      rx_accept  = fill_state && mem_rvalid && (recv_cnt_q < CNT_W'(BLOCK_WORDS));
      rx_last    = rx_accept && (recv_cnt_q == CNT_W'(BLOCK_WORDS - 1));
   end

   // next-state: fixed priority only in IDLE, no preemption elsewhere
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      base_d      = base_q;
      case (state_q)
         IDLE: begin
            if (d_write) begin
               state_d = WRITE;
            end else if (d_miss) begin
               state_d = D_FILL;
               base_d  = d_miss_addr[ADDR_W-1:OFF_W];
            end else if (i_miss) begin
               state_d = I_FILL;
               base_d  = i_miss_addr[ADDR_W-1:OFF_W];
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         I_FILL, D_FILL: begin
            if (issuing) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
            if (rx_accept) begin
               recv_cnt_d = recv_cnt_q + CNT_W'(1);
            end
            if (rx_last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // counters restart on every state change
      if (state_d != state_q) begin
         issue_cnt_d = '0;
         recv_cnt_d  = '0;
      end
   end

   // state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         base_q      <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         base_q      <= base_d;
      end
   end

   // output decode from registered state and counters
   always_comb begin
      mem_en      = is_write || issuing;
      mem_wr      = is_write;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (is_write) begin
         mem_addr  = d_write_addr;
         mem_wdata = d_write_data;
      end else if (issuing) begin
         // block base concatenated with word offset: no carry out of the block
         mem_addr  = {base_q, issue_cnt_q[IDX_W-1:0], 1'b0};
      end
      fill_data   = rx_accept ? mem_rdata : '0;
      fill_word   = rx_accept ? recv_cnt_q[IDX_W-1:0] : '0;
      i_fill_we   = rx_accept && (state_q == I_FILL);
      d_fill_we   = rx_accept && (state_q == D_FILL);
      i_fill_done = rx_last && (state_q == I_FILL);
      d_fill_done = rx_last && (state_q == D_FILL);
      d_write_ack = is_write;
      busy        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized requesters, fixed-latency memory,
// transaction-level reference model feeding scoreboard queues.
module tb_mem_arbiter;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 16;
   localparam int unsigned BW  = 8;
   localparam int          LAT = 4;
   localparam logic [15:0] KEY = 16'hA55A;

   logic          clk;
   logic          rst;
   logic          i_miss, d_miss, d_write;
   logic [AW-1:0] i_miss_addr, d_miss_addr, d_write_addr;
   logic [DW-1:0] d_write_data;
   logic          mem_en, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_rvalid;
   logic [DW-1:0] fill_data;
   logic [2:0]    fill_word;
   logic          i_fill_we, d_fill_we, i_fill_done, d_fill_done;
   logic          d_write_ack, busy;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_write(d_write), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .d_write_ack(d_write_ack), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] addr;
   } rd_t;

   int          cyc;
   int          n_checks, n_pass;
   logic [63:0] cmd_q[$];
   logic [63:0] fill_q[$];
   rd_t         mem_q[$];
   int          m_tx_start, m_tx_end;
   int          m_owner;   // 0 none, 1 store, 2 D fill, 3 I fill
   bit          m_fill;
   bit          in_rst;
   bit          spur_en;
   bit          want_i, want_d, want_w;
   logic [15:0] want_i_addr, want_d_addr, want_w_addr, want_w_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic report_unexpected(input string name, input logic [63:0] act);
      n_checks++;
      $display("FAIL %s cycle %0d: got %h expected nothing", name, cyc, act);
   endtask

   function automatic logic [63:0] cmd_rec(input int c, input logic wr, input logic [15:0] a,
                                           input logic [15:0] d, input logic ack);
      return 64'({16'(c), wr, a, d, ack});
   endfunction

   function automatic logic [63:0] fill_rec(input int c, input logic iw, input logic dw,
                                            input logic [2:0] w, input logic [15:0] d,
                                            input logic idn, input logic ddn);
      return 64'({16'(c), iw, dw, w, d, idn, ddn});
   endfunction

   // Reference model: when the arbiter is idle, grant the highest-priority
   // pending request and lay out its whole transaction in time.
   task automatic model_eval();
      logic [15:0] base;
      bit          is_d;
      if (cyc <= m_tx_end) return;
      if (d_write) begin
         m_owner    = 1;
         m_fill     = 0;
         m_tx_start = cyc + 1;
         m_tx_end   = cyc + 1;
         cmd_q.push_back(cmd_rec(cyc + 1, 1'b1, d_write_addr, d_write_data, 1'b1));
      end else if (d_miss || i_miss) begin
         is_d       = d_miss;
         base       = (is_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
         m_owner    = is_d ? 2 : 3;
         m_fill     = 1;
         m_tx_start = cyc + 1;
         m_tx_end   = cyc + LAT + BW;
         for (int k = 0; k < BW; k++) begin
            cmd_q.push_back(cmd_rec(cyc + 1 + k, 1'b0, base + 16'(2 * k), 16'h0, 1'b0));
            fill_q.push_back(fill_rec(cyc + 1 + LAT + k, !is_d, is_d, 3'(k),
                                      (base + 16'(2 * k)) ^ KEY,
                                      !is_d && (k == BW - 1), is_d && (k == BW - 1)));
         end
      end
   endtask

   // One clock of stimulus: requester protocol, memory returns, model update.
   task automatic tick(input bit rnd, input bit r);
      rd_t rd;
      bit  drop_i, drop_d, drop_w;
      @(posedge clk);
      #1;
      cyc++;
      rst        = r;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (r) begin
         in_rst = 1;
         cmd_q.delete();
         fill_q.delete();
         mem_q.delete();
         m_tx_start = -10;
         m_tx_end   = -10;
         m_owner    = 0;
         m_fill     = 0;
         return;
      end
      in_rst = 0;
      drop_i = 0; drop_d = 0; drop_w = 0;
      if (m_owner != 0 && cyc == m_tx_end + 1) begin
         case (m_owner)
            1: begin d_write = 1'b0; drop_w = 1; end
            2: begin d_miss  = 1'b0; drop_d = 1; end
            default: begin i_miss = 1'b0; drop_i = 1; end
         endcase
         m_owner = 0;
      end
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         rd         = mem_q.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = rd.addr ^ KEY;
      end else if (spur_en && !(m_fill && cyc >= m_tx_start && cyc <= m_tx_end)
                   && $urandom_range(0, 2) == 0) begin
         mem_rvalid = 1'b1;
      end
      if (!drop_i && !i_miss) begin
         if (want_i) begin
            i_miss = 1'b1; i_miss_addr = want_i_addr; want_i = 0;
         end else if (rnd && $urandom_range(0, 7) == 0) begin
            i_miss = 1'b1; i_miss_addr = 16'($urandom);
         end
      end
      if (!drop_d && !d_miss) begin
         if (want_d) begin
            d_miss = 1'b1; d_miss_addr = want_d_addr; want_d = 0;
         end else if (rnd && $urandom_range(0, 7) == 0) begin
            d_miss = 1'b1; d_miss_addr = 16'($urandom);
         end
      end
      if (!drop_w && !d_write) begin
         if (want_w) begin
            d_write = 1'b1; d_write_addr = want_w_addr; d_write_data = want_w_data; want_w = 0;
         end else if (rnd && $urandom_range(0, 9) == 0) begin
            d_write = 1'b1; d_write_addr = 16'($urandom); d_write_data = 16'($urandom);
         end
      end
      model_eval();
   endtask

   // Monitor: compares DUT activity against the scoreboard queues.
   always @(negedge clk) begin
      if (in_rst) begin
         check("reset_outputs",
               64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we,
                    d_fill_we, i_fill_done, d_fill_done, d_write_ack, busy}), 64'(0));
      end else begin
         check("busy", 64'(busy), 64'(cyc >= m_tx_start && cyc <= m_tx_end));
         if (mem_en) begin
            if (!mem_wr) mem_q.push_back('{cyc + LAT, mem_addr});
            if (cmd_q.size() == 0)
               report_unexpected("unexpected_cmd", cmd_rec(cyc, mem_wr, mem_addr, mem_wdata, d_write_ack));
            else
               check("mem_cmd", cmd_rec(cyc, mem_wr, mem_addr, mem_wdata, d_write_ack), cmd_q.pop_front());
         end else begin
            check("idle_bus", 64'({mem_wr, mem_addr, mem_wdata, d_write_ack}), 64'(0));
         end
         if (i_fill_we || d_fill_we) begin
            if (fill_q.size() == 0)
               report_unexpected("unexpected_fill", fill_rec(cyc, i_fill_we, d_fill_we, fill_word,
                                                             fill_data, i_fill_done, d_fill_done));
            else
               check("fill", fill_rec(cyc, i_fill_we, d_fill_we, fill_word, fill_data,
                                      i_fill_done, d_fill_done), fill_q.pop_front());
         end else begin
            check("stray_done", 64'({i_fill_done, d_fill_done}), 64'(0));
         end
      end
   end

   initial begin
      cyc = 0; n_checks = 0; n_pass = 0;
      m_tx_start = -10; m_tx_end = -10; m_owner = 0; m_fill = 0;
      in_rst = 1; spur_en = 0;
      want_i = 0; want_d = 0; want_w = 0;
      want_i_addr = '0; want_d_addr = '0; want_w_addr = '0; want_w_data = '0;
      rst = 1'b1;
      i_miss = 1'b0; d_miss = 1'b0; d_write = 1'b0;
      i_miss_addr = '0; d_miss_addr = '0; d_write_addr = '0; d_write_data = '0;
      mem_rdata = '0; mem_rvalid = 1'b0;

      tick(0, 1);
      tick(0, 1);
      tick(0, 0);

      // single I miss
      want_i = 1; want_i_addr = 16'h123F;
      repeat (16) tick(0, 0);

      // simultaneous D and I miss: D wins
      want_d = 1; want_d_addr = 16'h4002;
      want_i = 1; want_i_addr = 16'h8000;
      repeat (32) tick(0, 0);

      // store arriving during an I fill waits for completion
      want_i = 1; want_i_addr = 16'h2000;
      repeat (3) tick(0, 0);
      want_w = 1; want_w_addr = 16'h0010; want_w_data = 16'hBEEF;
      repeat (20) tick(0, 0);

      // store and D miss pending together: store first
      want_w = 1; want_w_addr = 16'h0100; want_w_data = 16'h1234;
      want_d = 1; want_d_addr = 16'h6A5B;
      repeat (20) tick(0, 0);

      // reset in the middle of a D fill with the miss still held
      want_d = 1; want_d_addr = 16'h7FF7;
      repeat (6) tick(0, 0);
      tick(0, 1);
      repeat (20) tick(0, 0);

      // spurious returns in IDLE and WRITE
      spur_en = 1;
      repeat (6) tick(0, 0);
      want_w = 1; want_w_addr = 16'h0010; want_w_data = 16'hBEEF;
      repeat (6) tick(0, 0);

      // randomized traffic
      repeat (1500) tick(1, 0);
      spur_en = 0;
      repeat (60) tick(0, 0);

      check("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
      check("fill_queue_drained", 64'(fill_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single pipelined main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the two cache controllers and unified memory, below the pipeline.
- The pipeline stalls on its cache miss signals. The arbiter owns all memory traffic until each fill completes.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width; a word is 2 bytes
BLOCK_WORDS, 8, words per cache block; power of two, >=2; block = 2*BLOCK_WORDS bytes

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
i_miss  in  1  I-cache miss request; held until i_fill_done
i_miss_addr  in  ADDR_W  faulting I-fetch address
d_miss  in  1  D-cache miss request; held until d_fill_done
d_miss_addr  in  ADDR_W  faulting D-access address
d_write  in  1  write-through store request; held until d_write_ack
d_write_addr  in  ADDR_W  store address
d_write_data  in  DATA_W  store data
mem_en  out  1  memory command valid
mem_wr  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid; fixed latency after each read issue
fill_data  out  DATA_W  equals mem_rdata
fill_word  out  log2(BLOCK_WORDS)  word index of fill_data within block
i_fill_we  out  1  write fill_data into I-cache data array
d_fill_we  out  1  write fill_data into D-cache data array
i_fill_done  out  1  one-cycle pulse: I block complete; I tag may be written
d_fill_done  out  1  one-cycle pulse: D block complete
d_write_ack  out  1  one-cycle pulse: store issued to memory
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, issue_cnt=0, recv_cnt=0, latched base address=0. All outputs are 0 while rst is high and in the first IDLE cycle after it.
- FSM states: IDLE, WRITE, I_FILL, D_FILL. Outputs decode combinationally from registered state and counters.
- IDLE: fixed priority, evaluated only here: d_write > d_miss > i_miss.
  - d_write goes to WRITE.
  - d_miss goes to D_FILL and latches base = d_miss_addr with low log2(2*BLOCK_WORDS) bits cleared.
  - i_miss goes to I_FILL and latches the I-side base the same way.
  - Counters clear on entry to any state.
- No preemption. Requests arriving during a transaction wait. Lower-priority requests never starve a fill in progress.
- WRITE: exactly one cycle. mem_en=1, mem_wr=1, mem_addr=d_write_addr, mem_wdata=d_write_data, d_write_ack=1. Next state is IDLE.
- I_FILL/D_FILL issue phase:
  - While issue_cnt<BLOCK_WORDS: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt.
  - issue_cnt increments each cycle. One read is issued per cycle, back-to-back.
- I_FILL/D_FILL receive phase:
  - Each cycle with mem_rvalid=1: the matching fill_we=1, fill_word=recv_cnt, then recv_cnt increments.
  - The receive phase overlaps the issue phase.
  - The arbiter does not count memory latency; it counts valids only.
- Completion: done pulses in the same cycle as the fill_we of word BLOCK_WORDS-1. Next state is IDLE.
- Request deassertion: the requester must drop its request in the cycle after done or ack. An IDLE cycle sees the request already low, so there is no re-issue.
- mem_rvalid outside I_FILL/D_FILL, or after recv_cnt has reached BLOCK_WORDS, is ignored: no fill_we and no counter change.
- mem_wr=0 and mem_wdata=0 whenever a write is not being issued. mem_addr=0 when mem_en=0.
- Counter widths: issue_cnt and recv_cnt are log2(BLOCK_WORDS)+1 bits. Base address addition has no carry into bits above the block offset.
- Reset mid-transaction: immediate return to IDLE, counters 0, no done pulse. The memory shares rst, so in-flight reads are discarded. A request still held after reset restarts the fill from word 0.
- busy=1 in every non-IDLE state, including the cycle that done pulses.

Test Plan:
- Single I-miss, memory latency 4: i_miss=1, addr 0x123F at cycle 0 -> mem_en reads 0x1230,0x1232..0x123E in cycles 1-8; i_fill_we with fill_word 0..7 in cycles 5-12; i_fill_done only in cycle 12; busy cycles 1-12.
- Simultaneous d_miss (0x4002) and i_miss (0x8000) at cycle 0 -> D fill first (reads 0x4000..0x400E, d_fill_done cycle 12); I fill reads start cycle 14; no i_fill_we during the D fill.
- d_write (0x0010, 0xBEEF) asserted in cycle 3 of an I fill -> I fill completes undisturbed; the next IDLE cycle goes to WRITE: one cycle mem_en=1, mem_wr=1, addr 0x0010, data 0xBEEF, d_write_ack=1.
- d_write and d_miss both pending in IDLE -> WRITE first (1 cycle), IDLE, then D_FILL; no overlap of write and read commands.
- rst pulsed in cycle 6 of a D fill with d_miss held -> all outputs 0 during rst; no d_fill_done; after release, the fill restarts with the read of word 0 at the base address.
- Spurious mem_rvalid=1 in IDLE and in WRITE -> no i_fill_we or d_fill_we, counters unchanged.
